tmds_decoder: RTL and testbench

Receive-side TMDS symbol decoder for one HDMI/DVI channel: takes parallel 10-bit symbols from the deserializer and recovers 8-bit pixel data, the 2-bit control code and the data-enable flag. It also runs the word-alignment state machine, which issues bitslip pulses to the deserializer until the channel locks on control tokens. One instance sits per channel, between the deserializer and the channel-deskew/video-timing logic.

---
 rtl/tmds_pkg.sv | 37 +++
 rtl/popcount8.sv | 14 +
 rtl/tmds_decoder.sv | 181 ++++++++++++++++++
 tb/tb_tmds_decoder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, alignment FSM states and the
// transition-minimisation (XOR/XNOR) selection rule.
package tmds_pkg;

  localparam int unsigned SYM_W  = 10;
  localparam int unsigned DATA_W = 8;

  localparam logic [SYM_W-1:0] TOKEN_00 = 10'h354;
  localparam logic [SYM_W-1:0] TOKEN_01 = 10'h0AB;
  localparam logic [SYM_W-1:0] TOKEN_10 = 10'h154;
  localparam logic [SYM_W-1:0] TOKEN_11 = 10'h2AB;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic is_token(input logic [SYM_W-1:0] s);
    return (s == TOKEN_00) || (s == TOKEN_01) || (s == TOKEN_10) || (s == TOKEN_11);
  endfunction

  function automatic logic [1:0] token_code(input logic [SYM_W-1:0] s);
    case (s)
      TOKEN_01: return 2'b01;
      TOKEN_10: return 2'b10;
      TOKEN_11: return 2'b11;
      default:  return 2'b00;
    endcase
  endfunction

  // XNOR chaining is chosen for bytes with many ones (ties broken by bit 0)
  function automatic logic use_xnor(input logic [3:0] n1, input logic d0);
    return (n1 > 4'd4) || ((n1 == 4'd4) && !d0);
  endfunction

endpackage

// File: rtl/popcount8.sv
// Ones counter for an 8-bit word.
module popcount8 (
  input  logic [7:0] d,
  output logic [3:0] count_c
);

  always_comb begin
    count_c = '0;
    for (int i = 0; i < 8; i++) begin
      count_c = count_c + 4'(d[i]);
    end
  end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: two-stage symbol decode plus word-alignment FSM
// that bitslips the deserializer until the channel locks on control tokens.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned LOCK_TOKENS   = 8,
  parameter int unsigned SEARCH_WINDOW = 1024,
  parameter int unsigned SLIP_WAIT     = 16,
  parameter int unsigned ERR_LIMIT     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sym_valid,
  input  logic [9:0]  sym,
  output logic        out_valid,
  output logic [7:0]  data_out,
  output logic [1:0]  ctrl_out,
  output logic        de_out,
  output logic        err_out,
  output logic        bitslip,
  output logic        locked
);

  localparam int unsigned RUN_W  = $clog2(LOCK_TOKENS) + 1;
  localparam int unsigned WIN_W  = $clog2(SEARCH_WINDOW) + 1;
  localparam int unsigned ERR_W  = $clog2(ERR_LIMIT) + 1;
  localparam int unsigned WAIT_W = $clog2(SLIP_WAIT) + 1;

  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(LOCK_TOKENS);
  localparam logic [WIN_W-1:0]  WIN_MAX  = WIN_W'(SEARCH_WINDOW);
  localparam logic [ERR_W-1:0]  ERR_MAX  = ERR_W'(ERR_LIMIT);
  localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(SLIP_WAIT - 1);

  // Stage 1: capture raw symbol
  logic             s1_valid;
  logic [SYM_W-1:0] s1_sym;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sym   <= '0;
    end else begin
      s1_valid <= sym_valid;
      if (sym_valid) s1_sym <= sym;
    end
  end

  // Stage 1 combinational decode and classification
  logic [DATA_W-1:0] dp_c;
  logic [DATA_W-1:0] d_c;
  logic [3:0]        n1_c;
  logic              tok_c;
  logic              err_c;

  always_comb begin
    dp_c   = s1_sym[9] ? ~s1_sym[7:0] : s1_sym[7:0];
    d_c    = '0;
    d_c[0] = dp_c[0];
    for (int i = 1; i < DATA_W; i++) begin
      d_c[i] = s1_sym[8] ? (dp_c[i] ^ dp_c[i-1]) : ~(dp_c[i] ^ dp_c[i-1]);
    end
  end

  popcount8 u_popcount8 (
    .d       (d_c),
    .count_c (n1_c)
  );

  assign tok_c = is_token(s1_sym);
  assign err_c = !tok_c && (use_xnor(n1_c, d_c[0]) == s1_sym[8]);

  // Stage 2: registered outputs; ctrl_out holds across data periods
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      ctrl_out  <= 2'b00;
      de_out    <= 1'b0;
      err_out   <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        de_out   <= !tok_c;
        err_out  <= err_c;
        data_out <= tok_c ? '0 : d_c;
        if (tok_c) ctrl_out <= token_code(s1_sym);
      end
    end
  end

  // Alignment FSM fed from stage-2 classification
  state_t            state_q, state_n;
  logic [RUN_W-1:0]  run_q, run_n, run_inc_c;
  logic [WIN_W-1:0]  win_q, win_n, win_inc_c;
  logic [ERR_W-1:0]  errs_q, errs_n, errs_inc_c;
  logic [WAIT_W-1:0] wait_q, wait_n;
  logic              slip_c;
  logic              s2_tok_c;

  assign s2_tok_c   = out_valid && !de_out;
  assign run_inc_c  = (run_q  == RUN_MAX) ? run_q  : run_q  + RUN_W'(1);
  assign win_inc_c  = (win_q  == WIN_MAX) ? win_q  : win_q  + WIN_W'(1);
  assign errs_inc_c = (errs_q == ERR_MAX) ? errs_q : errs_q + ERR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEARCH;
      run_q   <= '0;
      win_q   <= '0;
      errs_q  <= '0;
      wait_q  <= '0;
      bitslip <= 1'b0;
      locked  <= 1'b0;
    end else begin
      state_q <= state_n;
      run_q   <= run_n;
      win_q   <= win_n;
      errs_q  <= errs_n;
      wait_q  <= wait_n;
      bitslip <= slip_c;
      locked  <= (state_n == LOCKED);
    end
  end

  always_comb begin
    state_n = state_q;
    run_n   = run_q;
    win_n   = win_q;
    errs_n  = errs_q;
    wait_n  = wait_q;
    slip_c  = 1'b0;
    case (state_q)
      SEARCH: begin
        if (out_valid) begin
          run_n = s2_tok_c ? run_inc_c : '0;
          win_n = win_inc_c;
          // A completed token run takes priority over window expiry
          if (run_n == RUN_MAX) begin
            state_n = LOCKED;
            run_n   = '0;
            win_n   = '0;
            errs_n  = '0;
          end else if (win_n == WIN_MAX) begin
            state_n = SLIP;
            slip_c  = 1'b1;
            wait_n  = '0;
          end
        end
      end
      SLIP: begin
        if (wait_q == WAIT_END) begin
          state_n = SEARCH;
          run_n   = '0;
          win_n   = '0;
          wait_n  = '0;
        end else begin
          wait_n = wait_q + WAIT_W'(1);
        end
      end
      LOCKED: begin
        if (out_valid) begin
          if (s2_tok_c) begin
            run_n = run_inc_c;
            if (run_n == RUN_MAX) errs_n = '0;
          end else begin
            run_n = '0;
            if (err_out) errs_n = errs_inc_c;
            if (errs_n == ERR_MAX) begin
              state_n = SEARCH;
              run_n   = '0;
              win_n   = '0;
              errs_n  = '0;
            end
          end
        end
      end
      default: state_n = SEARCH;
    endcase
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder: constant vector table, alignment
// corner sequences, and random symbols against an encoder-inversion model.
module tb_tmds_decoder;

  logic       clk;
  logic       rst;
  logic       sym_valid;
  logic [9:0] sym;
  logic       out_valid;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic       de_out;
  logic       err_out;
  logic       bitslip;
  logic       locked;

  tmds_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .sym_valid (sym_valid),
    .sym       (sym),
    .out_valid (out_valid),
    .data_out  (data_out),
    .ctrl_out  (ctrl_out),
    .de_out    (de_out),
    .err_out   (err_out),
    .bitslip   (bitslip),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] sym;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
    logic       err;
  } vec_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
    logic       err;
  } exp_t;

  localparam logic [9:0] TOKS [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  int   n_pass = 0;
  int   n_total = 0;
  int   slip_pulses = 0;
  vec_t vecs [8];
  exp_t q [$];
  logic [1:0] last_ctrl;

  always @(posedge clk) if (bitslip) slip_pulses++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_zero(input string name);
    check(name, 32'({out_valid, data_out, ctrl_out, de_out, err_out, bitslip, locked}), 32'd0);
  endtask

  task automatic step(input logic v, input logic [9:0] s, input logic r = 1'b0);
    rst       = r;
    sym_valid = v;
    sym       = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 10'h000);
  endtask

  // Decode by searching for the byte whose TMDS encoding reproduces the symbol
  function automatic exp_t model(input logic [9:0] s);
    exp_t       e;
    logic [7:0] d;
    logic [7:0] qm;
    logic [7:0] qq;
    int         n1;
    logic       xn;
    e = '0;
    e.valid = 1'b1;
    for (int t = 0; t < 4; t++) begin
      if (s == TOKS[t]) begin
        e.ctrl = 2'(t);
        return e;
      end
    end
    e.de = 1'b1;
    for (int c = 0; c < 256; c++) begin
      d = 8'(c);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = s[8] ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
      qq = s[9] ? ~qm : qm;
      if (qq == s[7:0]) e.data = d;
    end
    n1 = $countones(e.data);
    xn = (n1 > 4) || ((n1 == 4) && !e.data[0]);
    e.err = (xn == s[8]);
    return e;
  endfunction

  initial begin
    exp_t e;
    exp_t got;
    logic v;
    logic [9:0] s;

    vecs[0] = '{10'h100, 8'h00, 2'b00, 1'b1, 1'b0};
    vecs[1] = '{10'h3FF, 8'h00, 2'b00, 1'b1, 1'b0};
    vecs[2] = '{10'h2FF, 8'hFE, 2'b00, 1'b1, 1'b0};
    vecs[3] = '{10'h155, 8'hFF, 2'b00, 1'b1, 1'b1};
    vecs[4] = '{10'h0AB, 8'h00, 2'b01, 1'b0, 1'b0};
    vecs[5] = '{10'h154, 8'h00, 2'b10, 1'b0, 1'b0};
    vecs[6] = '{10'h2AB, 8'h00, 2'b11, 1'b0, 1'b0};
    vecs[7] = '{10'h354, 8'h00, 2'b00, 1'b0, 1'b0};

    rst = 1'b1; sym_valid = 1'b0; sym = '0;
    step(1'b0, 10'h000, 1'b1);
    step(1'b0, 10'h000, 1'b1);
    check_zero("reset");

    // Initial lock on 0x354
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 10'h354);
      if (i == 1) check("tok_first_out", 32'({out_valid, de_out, ctrl_out}), 32'b1000);
    end
    idle(1);
    check("lock_early", 32'(locked), 32'd0);
    idle(1);
    check("lock", 32'(locked), 32'd1);
    check("lock_ctrl", 32'({de_out, ctrl_out}), 32'd0);
    check("lock_no_slip", 32'(slip_pulses), 32'd0);

    // Fixed decode vectors
    for (int i = 0; i < 8; i++) begin
      step(1'b1, vecs[i].sym);
      step(1'b0, 10'h000);
      check($sformatf("vec%0d_sym%03h", i, vecs[i].sym),
            32'({out_valid, de_out, err_out, ctrl_out, data_out}),
            32'({1'b1, vecs[i].de, vecs[i].err, vecs[i].ctrl, vecs[i].data}));
    end
    check("vec_locked", 32'(locked), 32'd1);

    // Clear errors with a token run, then walk errors up to the limit
    for (int i = 0; i < 8; i++) step(1'b1, 10'h354);
    for (int i = 0; i < 32; i++) step(1'b1, 10'h155);
    idle(1);
    check("err_below_limit", 32'(locked), 32'd1);
    idle(1);
    check("err_limit", 32'(locked), 32'd0);
    check("err_no_slip", 32'(slip_pulses), 32'd0);

    // Window expiry in SEARCH
    for (int i = 0; i < 1024; i++) step(1'b1, 10'h100);
    idle(1);
    check("slip_early", 32'(bitslip), 32'd0);
    idle(1);
    check("slip_pulse", 32'(bitslip), 32'd1);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 10'h0AB);
      if (i == 0) check("slip_width", 32'(bitslip), 32'd0);
    end
    idle(6);
    for (int i = 0; i < 7; i++) step(1'b1, 10'h0AB);
    idle(3);
    check("slip_tokens_ignored", 32'(locked), 32'd0);
    step(1'b1, 10'h0AB);
    idle(2);
    check("relock_after_slip", 32'({locked, ctrl_out}), 32'b101);
    check("slip_count", 32'(slip_pulses), 32'd1);

    // Reset while locked with symbols in flight
    step(1'b1, 10'h2FF);
    step(1'b1, 10'h2FF);
    step(1'b1, 10'h354, 1'b1);
    check_zero("rst_locked");
    idle(2);
    check("rst_flush", 32'(out_valid), 32'd0);
    for (int i = 0; i < 7; i++) step(1'b1, 10'h354);
    idle(2);
    check("relock_7", 32'(locked), 32'd0);
    step(1'b1, 10'h354);
    idle(2);
    check("relock_8", 32'(locked), 32'd1);

    // Reset during the slip wait
    step(1'b0, 10'h000, 1'b1);
    for (int i = 0; i < 1024; i++) step(1'b1, 10'h100);
    idle(2);
    check("slip2_pulse", 32'(bitslip), 32'd1);
    step(1'b0, 10'h000, 1'b1);
    check_zero("rst_slip");
    for (int i = 0; i < 8; i++) step(1'b1, 10'h154);
    idle(2);
    check("relock_after_rst", 32'({locked, ctrl_out}), 32'b110);
    check("slip2_count", 32'(slip_pulses), 32'd2);

    // Random symbols against the reference model
    step(1'b0, 10'h000, 1'b1);
    last_ctrl = 2'b00;
    q.delete();
    for (int c = 0; c < 2000; c++) begin
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) s = TOKS[$urandom_range(0, 3)];
      else s = 10'($urandom);
      if (v) begin
        e = model(s);
        if (!e.de) last_ctrl = e.ctrl;
        else e.ctrl = last_ctrl;
      end else begin
        e = '0;
      end
      q.push_back(e);
      step(v, s);
      if (q.size() == 2) begin
        e = q.pop_front();
        check($sformatf("rand%0d_valid", c), 32'(out_valid), 32'(e.valid));
        if (e.valid) begin
          got = {1'b1, data_out, ctrl_out, de_out, err_out};
          check($sformatf("rand%0d_decode", c), 32'(got), 32'(e));
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
